pause_dim_ctl: RTL and testbench
================================

# pause_dim_ctl

Parametrised pause and screen-dim controller between an arcade core's video output and `arcade_video`, inside the `emu` top level. It merges a user toggle, an OSD-open request and an external pause request into one core pause signal. User/OSD pauses take effect only on frame boundaries; the external request takes effect immediately. After a programmable idle time in pause, it dims the registered RGB stream by a programmable right shift per channel.

## Interface
Parameters:
- `RW`, default 3, red channel width.
- `GW`, default 3, green channel width.
- `BW`, default 2, blue channel width.
- `DIM_CYCLES`, default 240000000, number of paused clocks before dimming (10 s at 24 MHz); must be ≥1.
- `DIM_SHIFT`, default 1, right shift applied to each channel when dimmed; must be less than min(RW,GW,BW).

Ports:
- `clk_sys`, in, 1, single clock; all logic is synchronous to its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `user_button`, in, 1, level from the joystick; each rising edge toggles the user pause.
- `osd_open`, in, 1, OSD currently shown.
- `osd_pause_en`, in, 1, OSD option: pause while the OSD is open.
- `pause_request`, in, 1, level from an external agent (hiscore RAM access); immediate pause.
- `dim_en`, in, 1, enables dimming.
- `vblank`, in, 1, core vertical blank.
- `rgb_in`, in, RW+GW+BW, {r,g,b} from the core.
- `pause_cpu`, out, 1, pause to the core.
- `user_paused`, out, 1, state of the user toggle.
- `dimmed`, out, 1, dimming active.
- `rgb_out`, out, RW+GW+BW, registered {r,g,b} to the video pipeline.

## Operation
- **Edge detect.** `btn_q` holds the previous `user_button`. In reset, `btn_q` loads `user_button`, so a button held through reset does not toggle. Out of reset, `user_button & ~btn_q` toggles `user_paused`.
- **Frame-aligned request.** `soft_want = user_paused | (osd_open & osd_pause_en)`.
- **Frame-aligned latch.** `soft_paused` samples `soft_want` only on a vblank rising edge (`vblank & ~vblank_q`) and holds it otherwise.
- **Core pause.** `pause_cpu = soft_paused | pause_request`, registered. It asserts and deasserts one clock after `pause_request` changes.
- **Dim timer.** Width is $clog2(DIM_CYCLES+1).
  - Clears to 0 whenever `pause_cpu` is 0 or `dim_en` is 0.
  - Otherwise increments and saturates at DIM_CYCLES.
- **Dimmed flag.** `dimmed = (timer == DIM_CYCLES)`, registered.
- **Video path.** `rgb_out` registers each cycle.
  - Not dimmed: `rgb_out = rgb_in`.
  - Dimmed: each channel is logically right-shifted by DIM_SHIFT independently, with zero fill and no bits crossing channel boundaries.
- **Simultaneous events.**
  - A button edge on the same cycle as a vblank edge toggles `user_paused`. The vblank sample still uses the old `soft_want`, so the new value takes effect at the next vblank.
  - `pause_request` dropping while `soft_paused=1` keeps `pause_cpu=1`.
- **Mid-operation reset.** Clears all state in one cycle regardless of pause, dim or timer state.

## Timing
- **Reset values:** `pause_cpu=0`, `user_paused=0`, `dimmed=0`, `rgb_out=0`, timer=0, `soft_paused=0`, `vblank_q=0`.
- **`rgb_out` latency:** 1 clock from `rgb_in`. The dim select uses the `dimmed` register value from the same edge.
- **User pause latency:** from a button edge, `user_paused` updates at edge+1. `pause_cpu` rises 1 clock after the next vblank rising edge that sees `soft_want=1`.
- **Dim onset:** `dimmed` rises DIM_CYCLES+1 clocks after `pause_cpu` first reads 1, with `dim_en` held high.
- **Undim:** `dimmed` falls 1 clock after `pause_cpu` or `dim_en` falls. `rgb_out` is undimmed from the following clock.
- **Timer:** never wraps; it holds at DIM_CYCLES while paused.

## Test plan
1. **Reset:** `reset=1` for 2 clocks, then `rgb_in=8'hFF` → `rgb_out=8'hFF` after 1 clock; `pause_cpu=0`, `dimmed=0`.
2. **User toggle, frame aligned:** pulse `user_button` → `user_paused=1` next clock, `pause_cpu` stays 0. Raise `vblank` → `pause_cpu=1` 1 clock later. Pulse again, then raise `vblank` → `pause_cpu=0`.
3. **Dimming** (DIM_CYCLES=10, DIM_SHIFT=1, `dim_en=1`, `rgb_in=8'b111_111_11`):
   - Paused: `dimmed=1` exactly 11 clocks after `pause_cpu` rises; `rgb_out=8'b011_011_01` one clock later.
   - Unpause: `dimmed=0` and `rgb_out=8'hFF` within 2 clocks.
4. **External request:** `pause_request=1` in mid-frame → `pause_cpu=1` next clock with no vblank. Drop it → `pause_cpu=0` next clock, timer cleared.
5. **OSD gating:** `osd_open=1`, `osd_pause_en=0` plus vblank → `pause_cpu=0`. Set `osd_pause_en=1` plus vblank → `pause_cpu=1`.
6. **Reset corner cases:**
   - Button held high through reset → no toggle after release of reset.
   - Reset while dimmed → `dimmed=0`, `pause_cpu=0`, `user_paused=0` on the next clock.

Source files
------------

// File: rtl/pause_dim_ctl.sv
// Pause and screen-dim controller between the arcade core video output and the video pipeline.
// User and OSD pauses are applied at frame boundaries, and the external request is applied at once.
// After a programmable paused interval, each RGB channel is right-shifted.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// running     | pause_cpu=0, timer held at 0, video passes straight through
// paused      | pause_cpu=1, timer counting towards DIM_CYCLES
// paused_dim  | timer saturated at DIM_CYCLES, rgb_out channels shifted down
module pause_dim_ctl #(
    parameter int RW         = 3,
    parameter int GW         = 3,
    parameter int BW         = 2,
    parameter int DIM_CYCLES = 240000000,
    parameter int DIM_SHIFT  = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic                  osd_open,
    input  logic                  osd_pause_en,
    input  logic                  pause_request,
    input  logic                  dim_en,
    input  logic                  vblank,
    input  logic [RW+GW+BW-1:0]   rgb_in,
    output logic                  pause_cpu,
    output logic                  user_paused,
    output logic                  dimmed,
    output logic [RW+GW+BW-1:0]   rgb_out
);

    localparam int              TW     = $clog2(DIM_CYCLES + 1);
    localparam int              W      = RW + GW + BW;
    localparam logic [TW-1:0]   DIM_TC = TW'(DIM_CYCLES);

    logic          btn_q;
    logic          vblank_q;
    logic          soft_paused;
    logic [TW-1:0] timer;

    logic          soft_want;
    logic          vblank_rise;
    logic [RW-1:0] r_dim;
    logic [GW-1:0] g_dim;
    logic [BW-1:0] b_dim;

    assign soft_want   = user_paused | (osd_open & osd_pause_en);
    assign vblank_rise = vblank & ~vblank_q;

    // Each channel is shifted on its own, so no bit crosses into a neighbouring channel.
    assign r_dim = rgb_in[W-1 -: RW]     >> DIM_SHIFT;
    assign g_dim = rgb_in[GW+BW-1 -: GW] >> DIM_SHIFT;
    assign b_dim = rgb_in[BW-1:0]        >> DIM_SHIFT;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Loading the live button level prevents a button held through reset from toggling.
            btn_q       <= user_button;
            user_paused <= 1'b0;
            vblank_q    <= 1'b0;
            soft_paused <= 1'b0;
            pause_cpu   <= 1'b0;
            timer       <= '0;
            dimmed      <= 1'b0;
            rgb_out     <= '0;
        end else begin
            btn_q    <= user_button;
            vblank_q <= vblank;

            if (user_button && !btn_q)
                user_paused <= ~user_paused;

            if (vblank_rise)
                soft_paused <= soft_want;

            pause_cpu <= soft_paused | pause_request;

            if (!pause_cpu || !dim_en)
                timer <= '0;
            else if (timer != DIM_TC)
                timer <= timer + TW'(1);

            // The live gating lets the dimmed flag drop on the first clock after an unpause.
            dimmed <= (timer == DIM_TC) && pause_cpu && dim_en;

            if (dimmed)
                rgb_out <= {r_dim, g_dim, b_dim};
            else
                rgb_out <= rgb_in;
        end
    end

endmodule

// File: tb/tb_pause_dim_ctl.sv
// Self-checking bench for pause_dim_ctl with directed scenarios and a randomized phase.
// A behavioural model tracks the run length of paused cycles and uses plain arithmetic for the video.
module tb_pause_dim_ctl;

    localparam int RW = 3, GW = 3, BW = 2;
    localparam int W  = RW + GW + BW;
    localparam int DIM_CYCLES = 10;
    localparam int DIM_SHIFT  = 1;

    logic         clk_sys = 1'b0;
    logic         reset = 1'b1;
    logic         user_button = 1'b0;
    logic         osd_open = 1'b0;
    logic         osd_pause_en = 1'b0;
    logic         pause_request = 1'b0;
    logic         dim_en = 1'b0;
    logic         vblank = 1'b0;
    logic [W-1:0] rgb_in = '0;
    logic         pause_cpu;
    logic         user_paused;
    logic         dimmed;
    logic [W-1:0] rgb_out;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    pause_dim_ctl #(
        .RW(RW), .GW(GW), .BW(BW),
        .DIM_CYCLES(DIM_CYCLES), .DIM_SHIFT(DIM_SHIFT)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .user_button(user_button),
        .osd_open(osd_open),
        .osd_pause_en(osd_pause_en),
        .pause_request(pause_request),
        .dim_en(dim_en),
        .vblank(vblank),
        .rgb_in(rgb_in),
        .pause_cpu(pause_cpu),
        .user_paused(user_paused),
        .dimmed(dimmed),
        .rgb_out(rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    // Behavioural model
    bit m_btn_q, m_user, m_vb_q, m_soft, m_pause, m_dimmed;
    int m_run;
    int m_rgb;

    function automatic int dim_pixel(input int px);
        int r, g, b, sc;
        sc = 2 ** DIM_SHIFT;
        r = px / (2 ** (GW + BW));
        g = (px / (2 ** BW)) % (2 ** GW);
        b = px % (2 ** BW);
        return (r / sc) * (2 ** (GW + BW)) + (g / sc) * (2 ** BW) + (b / sc);
    endfunction

    always @(posedge clk_sys) begin
        bit n_user, n_soft, n_pause, want;
        int n_run, n_rgb;
        if (reset) begin
            m_btn_q = user_button;
            m_user = 0; m_vb_q = 0; m_soft = 0; m_pause = 0;
            m_run = 0; m_dimmed = 0; m_rgb = 0;
        end else begin
            want    = m_user | (osd_open & osd_pause_en);
            n_user  = m_user ^ (user_button & !m_btn_q);
            n_soft  = (vblank && !m_vb_q) ? want : m_soft;
            n_pause = m_soft | pause_request;
            n_run   = (m_pause && dim_en) ? m_run + 1 : 0;
            n_rgb   = m_dimmed ? dim_pixel(int'(rgb_in)) : int'(rgb_in);
            m_btn_q  = user_button;
            m_vb_q   = vblank;
            m_user   = n_user;
            m_soft   = n_soft;
            m_pause  = n_pause;
            m_run    = n_run;
            m_dimmed = (n_run >= DIM_CYCLES + 1);
            m_rgb    = n_rgb;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (check_en) begin
            check("model_pause_cpu", int'(pause_cpu), int'(m_pause));
            check("model_user_paused", int'(user_paused), int'(m_user));
            check("model_dimmed", int'(dimmed), int'(m_dimmed));
            check("model_rgb_out", int'(rgb_out), m_rgb);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        int frame_len, frame_pos;
        step(1);
        check_en = 1'b1;
        step(1);
        reset = 1'b0;
        rgb_in = 8'hFF;
        step(1);
        check("reset_rgb_pass", int'(rgb_out), 'hFF);
        check("reset_pause", int'(pause_cpu), 0);
        check("reset_dimmed", int'(dimmed), 0);

        // The user toggle is applied only at the frame boundary.
        user_button = 1'b1; step(1);
        check("toggle_user_paused", int'(user_paused), 1);
        check("toggle_no_pause_yet", int'(pause_cpu), 0);
        user_button = 1'b0; vblank = 1'b1; step(2);
        check("vblank_pause", int'(pause_cpu), 1);
        vblank = 1'b0; user_button = 1'b1; step(1);
        check("toggle_off", int'(user_paused), 0);
        user_button = 1'b0; vblank = 1'b1; step(2);
        check("vblank_unpause", int'(pause_cpu), 0);
        vblank = 1'b0; step(1);

        // The dim onset is DIM_CYCLES+1 clocks after pause_cpu rises.
        dim_en = 1'b1; rgb_in = 8'hFF;
        user_button = 1'b1; step(1);
        user_button = 1'b0; vblank = 1'b1; step(1);
        vblank = 1'b0; step(1);
        check("dim_pause_up", int'(pause_cpu), 1);
        step(10);
        check("dim_not_yet", int'(dimmed), 0);
        step(1);
        check("dim_onset", int'(dimmed), 1);
        step(1);
        check("dim_rgb", int'(rgb_out), 'h6D);
        user_button = 1'b1; step(1);
        user_button = 1'b0; vblank = 1'b1; step(1);
        vblank = 1'b0; step(1);
        check("unpause_cpu", int'(pause_cpu), 0);
        step(2);
        check("undim_flag", int'(dimmed), 0);
        check("undim_rgb", int'(rgb_out), 'hFF);

        // The external request takes effect without a vblank.
        pause_request = 1'b1; step(1);
        check("ext_pause", int'(pause_cpu), 1);
        pause_request = 1'b0; step(1);
        check("ext_release", int'(pause_cpu), 0);

        // OSD gating
        osd_open = 1'b1; osd_pause_en = 1'b0; vblank = 1'b1; step(2);
        check("osd_gated_off", int'(pause_cpu), 0);
        vblank = 1'b0; step(1);
        osd_pause_en = 1'b1; vblank = 1'b1; step(2);
        check("osd_pause", int'(pause_cpu), 1);
        vblank = 1'b0; step(1);
        osd_open = 1'b0; vblank = 1'b1; step(2);
        check("osd_close", int'(pause_cpu), 0);
        vblank = 1'b0; osd_pause_en = 1'b0; step(1);

        // A button held through reset must not toggle.
        user_button = 1'b1; reset = 1'b1; step(2);
        reset = 1'b0; step(2);
        check("held_btn_no_toggle", int'(user_paused), 0);
        user_button = 1'b0; step(1);

        // Reset while dimmed
        user_button = 1'b1; step(1);
        user_button = 1'b0; pause_request = 1'b1; step(12);
        check("pre_reset_dimmed", int'(dimmed), 1);
        check("pre_reset_user", int'(user_paused), 1);
        reset = 1'b1; step(1);
        check("rst_dimmed", int'(dimmed), 0);
        check("rst_pause", int'(pause_cpu), 0);
        check("rst_user", int'(user_paused), 0);
        reset = 1'b0; pause_request = 1'b0; step(1);

        // Randomized phase
        frame_len = 30; frame_pos = 0;
        for (int i = 0; i < 4000; i++) begin
            rgb_in = W'($urandom_range(0, (2 ** W) - 1));
            if ($urandom_range(0, 19) == 0) user_button = ~user_button;
            if ($urandom_range(0, 59) == 0) pause_request = ~pause_request;
            if ($urandom_range(0, 79) == 0) osd_open = ~osd_open;
            if ($urandom_range(0, 99) == 0) osd_pause_en = ~osd_pause_en;
            if ($urandom_range(0, 149) == 0) dim_en = ~dim_en;
            reset = ($urandom_range(0, 499) == 0);
            frame_pos++;
            if (frame_pos >= frame_len) begin
                frame_pos = 0;
                frame_len = $urandom_range(15, 40);
            end
            vblank = (frame_pos < 3);
            step(1);
        end
        reset = 1'b0;
        step(2);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
